// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-path constants and the fetch-buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_LENGTH = 32;
    localparam int ADDR_WIDTH   = 5;

    localparam logic [PC_WIDTH-1:0]     RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_LENGTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_WIDTH-1:0]     pc;
        logic [INSTR_LENGTH-1:0] instr;
    } fetch_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries; flush overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer is the wrap bit that separates full from empty
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    fetch_entry_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    assign head = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked by the empty flag downstream
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and imem read initiator feeding decode through a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                    PC_WIDTH     = riscv_pkg::PC_WIDTH,
    parameter int                    ADDR_WIDTH   = riscv_pkg::ADDR_WIDTH,
    parameter int                    INSTR_LENGTH = riscv_pkg::INSTR_LENGTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = riscv_pkg::RESET_PC,
    parameter int                    FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [INSTR_LENGTH-1:0] imem_instr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_LENGTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]     instr_pc,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc
);

    import riscv_pkg::fetch_entry_t;
    import riscv_pkg::NOP_INSTR;

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;
    logic                w_unused_redirect_lsb;

    // Redirect targets are word aligned; the low bits carry no information
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr = r_fetch_pc[ADDR_WIDTH+1:2];

    assign w_pop  = ~w_empty & instr_ready;
    assign w_push = fetch_en & ~redirect_valid & (~w_full | w_pop);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = r_fetch_pc;
        w_push_entry.instr = imem_instr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .push_entry (w_push_entry),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head)
    );

    // Empty buffer presents a NOP at the reset PC so decode never sees stale data
    always_comb begin
        instr_valid = ~w_empty;
        instr_data  = NOP_INSTR;
        instr_pc    = RESET_PC;
        if (!w_empty) begin
            instr_data = w_head.instr;
            instr_pc   = w_head.pc;
        end
    end

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [4:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mem [32];
    int          total;
    int          bad;

    assign imem_instr = mem[imem_addr];

    instr_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic en, input logic rdy);
        @(negedge clk);
        rst            = 1'b0;
        fetch_en       = en;
        instr_ready    = rdy;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== c_NOP) begin bad++; $display("FAIL reset_data got=%h exp=%h", instr_data, c_NOP); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        total++; if (imem_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b exp=0", instr_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_data [4];
        exp_data = '{32'h0000_0193, 32'h0010_0213, 32'h0020_0293, 32'h0050_01B3};
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, instr_valid); end
            total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, 32'(4 * i)); end
            total++; if (instr_data !== exp_data[i]) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, instr_data, exp_data[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_data [4];
        exp_data = '{32'h0000_0193, 32'h0010_0213, 32'h0020_0293, 32'h0050_01B3};
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, instr_valid); end
            total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_hold_pc[%0d] got=%h exp=0", i, instr_pc); end
            total++; if (instr_data !== exp_data[0]) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h exp=%h", i, instr_data, exp_data[0]); end
        end
        total++; if (imem_addr !== 5'd2) begin bad++; $display("FAIL bp_fetch_pc_hold got=%0d exp=2", imem_addr); end
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL bp_drain_pc[%0d] got=%h exp=%h", i, instr_pc, 32'(4 * i)); end
            total++; if (instr_data !== exp_data[i]) begin bad++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", i, instr_data, exp_data[i]); end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (imem_addr !== 5'd2) begin bad++; $display("FAIL redir_pre_addr got=%0d exp=2", imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000E;
        instr_ready    = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== c_NOP) begin bad++; $display("FAIL redir_flush_data got=%h exp=%h", instr_data, c_NOP); end
        total++; if (imem_addr !== 5'd3) begin bad++; $display("FAIL redir_target_addr got=%0d exp=3", imem_addr); end
        @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL redir_out_valid got=%b exp=1", instr_valid); end
        total++; if (instr_pc !== 32'h0000_000C) begin bad++; $display("FAIL redir_out_pc got=%h exp=0000000c", instr_pc); end
        total++; if (instr_data !== 32'h0050_01B3) begin bad++; $display("FAIL redir_out_data got=%h exp=005001b3", instr_data); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_first_valid got=%b exp=0", instr_valid); end
        redirect_pc = 32'h0000_0004;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_second_valid got=%b exp=0", instr_valid); end
        total++; if (imem_addr !== 5'd1) begin bad++; $display("FAIL b2b_addr got=%0d exp=1", imem_addr); end
        @(negedge clk);
        total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL b2b_pc got=%h exp=4", instr_pc); end
        total++; if (instr_data !== 32'h0010_0213) begin bad++; $display("FAIL b2b_data got=%h exp=00100213", instr_data); end
        @(negedge clk);
        total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL b2b_next_pc got=%h exp=8", instr_pc); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_007C;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 5'd31) begin bad++; $display("FAIL wrap_addr_7c got=%0d exp=31", imem_addr); end
        @(negedge clk);
        total++; if (instr_pc !== 32'h7C) begin bad++; $display("FAIL wrap_pc_7c got=%h exp=7c", instr_pc); end
        total++; if (instr_data !== 32'hA5A5_001F) begin bad++; $display("FAIL wrap_data_7c got=%h exp=a5a5001f", instr_data); end
        total++; if (imem_addr !== 5'd0) begin bad++; $display("FAIL wrap_addr_80 got=%0d exp=0", imem_addr); end
        @(negedge clk);
        total++; if (instr_pc !== 32'h80) begin bad++; $display("FAIL wrap_pc_80 got=%h exp=80", instr_pc); end
        total++; if (instr_data !== 32'h0000_0193) begin bad++; $display("FAIL wrap_data_80 got=%h exp=00000193", instr_data); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc_top got=%h exp=fffffffc", instr_pc); end
        total++; if (instr_data !== 32'hA5A5_001F) begin bad++; $display("FAIL wrap_data_top got=%h exp=a5a5001f", instr_data); end
        @(negedge clk);
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc_zero got=%h exp=0", instr_pc); end
        total++; if (instr_data !== 32'h0000_0193) begin bad++; $display("FAIL wrap_data_zero got=%h exp=00000193", instr_data); end
    endtask

    task automatic test_fetch_disable();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL dis_drain_pc got=%h exp=4", instr_pc); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL dis_drain_valid got=%b exp=1", instr_valid); end
        repeat (2) @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL dis_empty_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== c_NOP) begin bad++; $display("FAIL dis_empty_data got=%h exp=%h", instr_data, c_NOP); end
        total++; if (imem_addr !== 5'd2) begin bad++; $display("FAIL dis_held_addr got=%0d exp=2", imem_addr); end
        fetch_en = 1'b1;
        @(negedge clk);
        total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL dis_resume_pc got=%h exp=8", instr_pc); end
        total++; if (instr_data !== 32'h0020_0293) begin bad++; $display("FAIL dis_resume_data got=%h exp=00200293", instr_data); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ares_pre_valid got=%b exp=1", instr_valid); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ares_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== c_NOP) begin bad++; $display("FAIL ares_data got=%h exp=%h", instr_data, c_NOP); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ares_pc got=%h exp=0", instr_pc); end
        total++; if (imem_addr !== 5'd0) begin bad++; $display("FAIL ares_addr got=%0d exp=0", imem_addr); end
        @(negedge clk);
        rst         = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ares_first_pc got=%h exp=0", instr_pc); end
        total++; if (instr_data !== 32'h0000_0193) begin bad++; $display("FAIL ares_first_data got=%h exp=00000193", instr_data); end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        total          = 0;
        bad            = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = {16'hA5A5, 16'(i)};
        end
        mem[0] = 32'h0000_0193;
        mem[1] = 32'h0010_0213;
        mem[2] = 32'h0020_0293;
        mem[3] = 32'h0050_01B3;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_fetch_disable();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
